// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high time and rise-to-rise period of a 50 Hz
// servo pulse train and converts the high time back to an angle of 0..180.
module servo_pwm_decoder #(
  parameter int unsigned CLOCK_FREQ    = 50_000_000,
  parameter int unsigned MIN_PULSE_CYC = CLOCK_FREQ / 1000,
  parameter int unsigned MAX_PULSE_CYC = CLOCK_FREQ / 500,
  parameter int unsigned TIMEOUT_CYC   = (CLOCK_FREQ / 100) * 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [7:0]  angle,
  output logic        angle_valid,
  output logic [31:0] pulse_width,
  output logic [31:0] period_cycles,
  output logic        out_of_range,
  output logic        signal_lost
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic [31:0] MIN_W     = 32'(MIN_PULSE_CYC);
  localparam logic [31:0] MAX_W     = 32'(MAX_PULSE_CYC);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYC);
  localparam logic [39:0] DIV_W     = 40'(MAX_PULSE_CYC - MIN_PULSE_CYC);
  localparam logic [39:0] FULL_W    = DIV_W * 40'd180;

  state_t      state_r;
  state_t      state_s;
  logic        sync1_r;
  logic        sync2_r;
  logic        prev_r;
  logic [1:0]  warm_r;
  logic        warm_done_s;
  logic        rise_s;
  logic        fall_s;
  logic [31:0] hi_cnt_r;
  logic [31:0] per_cnt_r;
  logic        start_s;
  logic        hi_inc_s;
  logic        per_inc_s;
  logic        launch_s;
  logic        period_upd_s;
  logic        timeout_s;
  logic [39:0] num_s;
  logic        oor_s;
  logic        conv_busy_r;
  logic [3:0]  step_r;
  logic [39:0] rem_r;
  logic [39:0] dvs_r;
  logic [7:0]  quo_r;
  logic        oor_r;
  logic        ge_s;
  logic        done_s;

  assign warm_done_s = (warm_r == 2'd2);
  assign rise_s      = sync2_r & ~prev_r;
  assign fall_s      = ~sync2_r & prev_r;
  assign ge_s        = (rem_r >= dvs_r);
  assign done_s      = conv_busy_r & (step_r == 4'd8) & ~launch_s;

  // Input synchronizer, edge-detect delay and post-reset warm-up counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      warm_r  <= 2'd0;
    end else begin
      sync1_r <= pwm_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (!warm_done_s) begin
        warm_r <= warm_r + 2'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    state_s      = state_r;
    start_s      = 1'b0;
    hi_inc_s     = 1'b0;
    per_inc_s    = 1'b0;
    launch_s     = 1'b0;
    period_upd_s = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Zeros left in the synchronizer by reset are not a real low level.
        if (warm_done_s && !sync2_r) begin
          state_s = ST_ARMED;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (rise_s) begin
          state_s = ST_HIGH;
          start_s = 1'b1;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_HIGH: begin
        if (fall_s) begin
          state_s   = ST_LOW;
          launch_s  = 1'b1;
          per_inc_s = 1'b1;
        end else if (hi_cnt_r == TIMEOUT_W) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          hi_inc_s  = 1'b1;
          per_inc_s = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          state_s      = ST_HIGH;
          start_s      = 1'b1;
          period_upd_s = 1'b1;
        end else if (per_cnt_r == TIMEOUT_W) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          per_inc_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // High-time and period counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt_r  <= 32'd0;
      per_cnt_r <= 32'd0;
    end else if (start_s) begin
      hi_cnt_r  <= 32'd1;
      per_cnt_r <= 32'd1;
    end else begin
      if (hi_inc_s) begin
        hi_cnt_r <= hi_cnt_r + 32'd1;
      end
      if (per_inc_s) begin
        per_cnt_r <= per_cnt_r + 32'd1;
      end
    end
  end

  // Raw measurement outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_width   <= 32'd0;
      period_cycles <= 32'd0;
    end else begin
      if (launch_s) begin
        pulse_width <= hi_cnt_r;
      end
      if (period_upd_s) begin
        period_cycles <= per_cnt_r;
      end
    end
  end

  // Divider setup: out-of-range widths are clamped so every case takes the same path.
  always_comb begin
    num_s = 40'd0;
    oor_s = 1'b0;
    if (hi_cnt_r < MIN_W) begin
      num_s = 40'd0;
      oor_s = 1'b1;
    end else if (hi_cnt_r > MAX_W) begin
      num_s = FULL_W;
      oor_s = 1'b1;
    end else begin
      num_s = 40'(hi_cnt_r - MIN_W) * 40'd180;
      oor_s = 1'b0;
    end
  end

  // Restoring divider: load, 8 quotient bits MSB first, then publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_busy_r  <= 1'b0;
      step_r       <= 4'd0;
      rem_r        <= 40'd0;
      dvs_r        <= 40'd0;
      quo_r        <= 8'd0;
      oor_r        <= 1'b0;
      angle        <= 8'd0;
      out_of_range <= 1'b0;
      angle_valid  <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      if (launch_s) begin
        conv_busy_r <= 1'b1;
        step_r      <= 4'd0;
        rem_r       <= num_s;
        dvs_r       <= DIV_W << 7;
        quo_r       <= 8'd0;
        oor_r       <= oor_s;
      end else if (done_s) begin
        conv_busy_r  <= 1'b0;
        angle        <= quo_r;
        out_of_range <= oor_r;
        angle_valid  <= 1'b1;
      end else if (conv_busy_r) begin
        if (ge_s) begin
          rem_r <= rem_r - dvs_r;
        end
        quo_r  <= {quo_r[6:0], ge_s};
        dvs_r  <= dvs_r >> 1;
        step_r <= step_r + 4'd1;
      end
    end
  end

  // Sticky loss flag; a timeout wins over a coincident publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      signal_lost <= 1'b0;
    end else if (timeout_s) begin
      signal_lost <= 1'b1;
    end else if (done_s) begin
      signal_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder: table of pulses with hand-computed
// angles plus sequences for startup, loss, glitch abort and mid-conversion reset.
module tb_servo_pwm_decoder;

  localparam int LAT = 12;

  logic        clk;
  logic        rst;
  logic        pwm_in;
  logic [7:0]  angle;
  logic        angle_valid;
  logic [31:0] pulse_width;
  logic [31:0] period_cycles;
  logic        out_of_range;
  logic        signal_lost;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int valid_cnt = 0;
  int v_cyc  = 0;
  int v_angle = 0;
  int v_oor  = 0;
  int fall_cyc = 0;

  typedef struct {
    int high;
    int low;
    int exp_angle;
    int exp_oor;
    int exp_period;
  } vec_t;

  vec_t vecs [8];

  servo_pwm_decoder #(
    .CLOCK_FREQ   (50_000_000),
    .MIN_PULSE_CYC(500),
    .MAX_PULSE_CYC(1000),
    .TIMEOUT_CYC  (15000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .angle        (angle),
    .angle_valid  (angle_valid),
    .pulse_width  (pulse_width),
    .period_cycles(period_cycles),
    .out_of_range (out_of_range),
    .signal_lost  (signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every angle_valid strobe and the values published with it.
  always @(negedge clk) begin
    if (angle_valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      v_cyc     <= cyc;
      v_angle   <= int'(angle);
      v_oor     <= int'(out_of_range);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One pulse (high h, then low l), then check everything the pulse should publish.
  task automatic apply(input int h, input int l, input int exp_a, input int exp_o,
                       input int exp_p, input string tag);
    int v0;
    v0 = valid_cnt;
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    fall_cyc = cyc;
    repeat (l) @(negedge clk);
    chk({tag, " valid_count"}, 64'(valid_cnt - v0), 64'd1);
    chk({tag, " latency"}, 64'(v_cyc - fall_cyc), 64'(LAT));
    chk({tag, " angle"}, 64'(v_angle), 64'(exp_a));
    chk({tag, " out_of_range"}, 64'(v_oor), 64'(exp_o));
    chk({tag, " pulse_width"}, 64'(pulse_width), 64'(h));
    chk({tag, " period"}, 64'(period_cycles), 64'(exp_p));
    chk({tag, " signal_lost"}, 64'(signal_lost), 64'd0);
  endtask

  initial begin
    int v0;
    vecs[0] = '{high: 750,  low: 9250, exp_angle: 90,  exp_oor: 0, exp_period: 0};
    vecs[1] = '{high: 750,  low: 9250, exp_angle: 90,  exp_oor: 0, exp_period: 10000};
    vecs[2] = '{high: 750,  low: 9250, exp_angle: 90,  exp_oor: 0, exp_period: 10000};
    vecs[3] = '{high: 500,  low: 1500, exp_angle: 0,   exp_oor: 0, exp_period: 10000};
    vecs[4] = '{high: 1000, low: 1000, exp_angle: 180, exp_oor: 0, exp_period: 2000};
    vecs[5] = '{high: 600,  low: 1400, exp_angle: 36,  exp_oor: 0, exp_period: 2000};
    vecs[6] = '{high: 400,  low: 1600, exp_angle: 0,   exp_oor: 1, exp_period: 2000};
    vecs[7] = '{high: 1200, low: 800,  exp_angle: 180, exp_oor: 1, exp_period: 2000};

    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset angle", 64'(angle), 64'd0);
    chk("reset angle_valid", 64'(angle_valid), 64'd0);
    chk("reset pulse_width", 64'(pulse_width), 64'd0);
    chk("reset period", 64'(period_cycles), 64'd0);
    chk("reset out_of_range", 64'(out_of_range), 64'd0);
    chk("reset signal_lost", 64'(signal_lost), 64'd0);

    // Pulse already high when reset releases must never be measured.
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (500) @(negedge clk);
    chk("startup no valid", 64'(valid_cnt), 64'd0);
    chk("startup pulse_width", 64'(pulse_width), 64'd0);

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].high, vecs[i].low, vecs[i].exp_angle, vecs[i].exp_oor,
            vecs[i].exp_period, $sformatf("vec%0d", i));
    end

    // Signal loss: line stays low well past the timeout.
    v0 = valid_cnt;
    repeat (11000) @(negedge clk);
    chk("loss early", 64'(signal_lost), 64'd0);
    repeat (5000) @(negedge clk);
    chk("loss flag", 64'(signal_lost), 64'd1);
    chk("loss angle held", 64'(angle), 64'd180);
    chk("loss no valid", 64'(valid_cnt - v0), 64'd0);
    apply(750, 1000, 90, 0, 2000, "recover");

    // Glitch during conversion aborts the first result.
    v0 = valid_cnt;
    pwm_in = 1'b1;
    repeat (800) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    pwm_in = 1'b0;
    fall_cyc = cyc;
    repeat (300) @(negedge clk);
    chk("glitch valid_count", 64'(valid_cnt - v0), 64'd1);
    chk("glitch latency", 64'(v_cyc - fall_cyc), 64'(LAT));
    chk("glitch angle", 64'(v_angle), 64'd0);
    chk("glitch out_of_range", 64'(v_oor), 64'd1);
    chk("glitch pulse_width", 64'(pulse_width), 64'd5);

    // Reset three cycles after a fall drops the conversion.
    v0 = valid_cnt;
    pwm_in = 1'b1;
    repeat (750) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst no valid", 64'(valid_cnt - v0), 64'd0);
    chk("midrst angle", 64'(angle), 64'd0);
    chk("midrst pulse_width", 64'(pulse_width), 64'd0);
    chk("midrst period", 64'(period_cycles), 64'd0);
    chk("midrst out_of_range", 64'(out_of_range), 64'd0);
    chk("midrst signal_lost", 64'(signal_lost), 64'd0);
    apply(750, 1000, 90, 0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
